// File: rtl/muu_resp_framer.sv
// Store-and-forward response framer: buffers whole packets, then emits one metadata beat followed by the data words.
// Latency: last word accepted at N -> tx_meta_valid at N+2; meta handshake at M -> first tx_valid at M+1.
// Backpressure: in_ready drops when the word buffer or the meta queue is full; tx valids hold until accepted.
module muu_resp_framer #(
  parameter int META_WIDTH    = 96,
  parameter int DATA_WIDTH    = 512,
  parameter int SESSION_LSB   = 0,
  parameter int DEPTH_LOG2    = 5,
  parameter int MQ_DEPTH_LOG2 = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [META_WIDTH+DATA_WIDTH-1:0] in_data,
  input  logic [7:0]                       in_user,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [31:0]                      tx_meta_data,
  output logic [7:0]                       tx_meta_user,
  output logic                             tx_meta_valid,
  input  logic                             tx_meta_ready,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic [DATA_WIDTH/8-1:0]          tx_keep,
  output logic                             tx_valid,
  output logic                             tx_last,
  input  logic                             tx_ready,
  output logic [31:0]                      pkt_count,
  output logic [15:0]                      trunc_count
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int MQ_DEPTH = 1 << MQ_DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] session;
    logic [7:0]  user;
    logic [15:0] len;
  } mq_entry_t;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_META, R_DATA} rstate_t;

  // Word buffer: {word, last}; pointers carry an extra wrap bit
  logic [DATA_WIDTH:0]   buf_mem [DEPTH];
  logic [DEPTH_LOG2:0]   buf_wr_q, buf_rd_q;
  logic                  buf_full, buf_empty, buf_push, buf_pop;
  logic [DATA_WIDTH:0]   buf_head;

  // Meta queue: one entry per closed packet
  mq_entry_t             mq_mem [MQ_DEPTH];
  logic [MQ_DEPTH_LOG2:0] mq_wr_q, mq_rd_q;
  logic                  mq_full, mq_empty, mq_push, mq_pop;
  mq_entry_t             mq_head, mq_push_dat;

  // Write side
  wstate_t               wstate_q, wstate_d;
  logic [DEPTH_LOG2:0]   wcnt_q, wcnt_d, cnt_next;
  logic [15:0]           sess_q, sess_d, cur_sess;
  logic [7:0]            user_q, user_d, cur_user;
  logic [15:0]           trunc_q, trunc_d;
  logic                  first_word, at_limit, pkt_close, in_fire;

  // Read side
  rstate_t               rstate_q, rstate_d;
  logic [31:0]           meta_dat_q, meta_dat_d;
  logic [7:0]            meta_user_q, meta_user_d;
  logic                  meta_vld_q, meta_vld_d;
  logic [31:0]           pkt_q, pkt_d;

  // Low until the first clock after reset release, so in_ready and tx_keep read 0 during reset
  logic                  run_q;

  // Only the session field of the upstream metadata is consumed
  logic                  unused_meta;
  assign unused_meta = ^in_data[META_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  assign buf_empty = (buf_wr_q == buf_rd_q);
  assign buf_full  = (buf_wr_q[DEPTH_LOG2] != buf_rd_q[DEPTH_LOG2]) &&
                     (buf_wr_q[DEPTH_LOG2-1:0] == buf_rd_q[DEPTH_LOG2-1:0]);
  assign buf_head  = buf_mem[buf_rd_q[DEPTH_LOG2-1:0]];

  assign mq_empty  = (mq_wr_q == mq_rd_q);
  assign mq_full   = (mq_wr_q[MQ_DEPTH_LOG2] != mq_rd_q[MQ_DEPTH_LOG2]) &&
                     (mq_wr_q[MQ_DEPTH_LOG2-1:0] == mq_rd_q[MQ_DEPTH_LOG2-1:0]);
  assign mq_head   = mq_mem[mq_rd_q[MQ_DEPTH_LOG2-1:0]];

  // Occupancy only: a same-cycle pop does not reopen a full buffer
  assign in_ready  = run_q && !buf_full && !mq_full;
  assign in_fire   = in_valid && in_ready;

  // A packet closes on last, or when it reaches the buffer depth (forced close avoids deadlock)
  assign first_word = (wstate_q == W_IDLE);
  assign cnt_next   = first_word ? CNT_ONE : wcnt_q + CNT_ONE;
  assign at_limit   = (cnt_next == DEPTH_CNT);
  assign pkt_close  = in_last || at_limit;
  assign cur_sess   = first_word ? in_data[DATA_WIDTH+SESSION_LSB +: 16] : sess_q;
  assign cur_user   = first_word ? in_user : user_q;
  assign mq_push_dat = '{session: cur_sess, user: cur_user, len: 16'(cnt_next) << 6};
  assign buf_push   = in_fire;
  assign mq_push    = in_fire && pkt_close;

  // Write FSM next state: track word count, latch session/user on first word, count truncations
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    sess_d   = sess_q;
    user_d   = user_q;
    trunc_d  = trunc_q;
    if (in_fire) begin
      wcnt_d   = cnt_next;
      sess_d   = cur_sess;
      user_d   = cur_user;
      wstate_d = pkt_close ? W_IDLE : W_FILL;
      if (at_limit && !in_last && trunc_q != 16'hFFFF) begin
        trunc_d = trunc_q + 16'd1;
      end
    end
  end

  // Read FSM next state: load meta from queue head, wait for its handshake, then stream words to last
  always_comb begin
    rstate_d    = rstate_q;
    meta_dat_d  = meta_dat_q;
    meta_user_d = meta_user_q;
    meta_vld_d  = meta_vld_q;
    pkt_d       = pkt_q;
    mq_pop      = 1'b0;
    buf_pop     = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (!mq_empty) begin
          meta_dat_d  = {mq_head.session, mq_head.len};
          meta_user_d = mq_head.user;
          meta_vld_d  = 1'b1;
          rstate_d    = R_META;
        end
      end
      R_META: begin
        if (tx_meta_ready) begin
          mq_pop     = 1'b1;
          meta_vld_d = 1'b0;
          pkt_d      = pkt_q + 32'd1;
          rstate_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (tx_valid && tx_ready) begin
          buf_pop = 1'b1;
          if (buf_head[0]) begin
            rstate_d = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // State, pointer and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      mq_wr_q     <= '0;
      mq_rd_q     <= '0;
      wstate_q    <= W_IDLE;
      wcnt_q      <= '0;
      sess_q      <= '0;
      user_q      <= '0;
      trunc_q     <= '0;
      rstate_q    <= R_IDLE;
      meta_dat_q  <= '0;
      meta_user_q <= '0;
      meta_vld_q  <= 1'b0;
      pkt_q       <= '0;
    end else begin
      run_q       <= 1'b1;
      if (buf_push) buf_wr_q <= buf_wr_q + 1'b1;
      if (buf_pop)  buf_rd_q <= buf_rd_q + 1'b1;
      if (mq_push)  mq_wr_q  <= mq_wr_q + 1'b1;
      if (mq_pop)   mq_rd_q  <= mq_rd_q + 1'b1;
      wstate_q    <= wstate_d;
      wcnt_q      <= wcnt_d;
      sess_q      <= sess_d;
      user_q      <= user_d;
      trunc_q     <= trunc_d;
      rstate_q    <= rstate_d;
      meta_dat_q  <= meta_dat_d;
      meta_user_q <= meta_user_d;
      meta_vld_q  <= meta_vld_d;
      pkt_q       <= pkt_d;
    end
  end

  // Storage arrays; the word that closes a packet is stored with last set
  always_ff @(posedge clk) begin
    if (buf_push) buf_mem[buf_wr_q[DEPTH_LOG2-1:0]] <= {in_data[DATA_WIDTH-1:0], pkt_close};
    if (mq_push)  mq_mem[mq_wr_q[MQ_DEPTH_LOG2-1:0]] <= mq_push_dat;
  end

  assign tx_meta_data  = meta_dat_q;
  assign tx_meta_user  = meta_user_q;
  assign tx_meta_valid = meta_vld_q;
  assign tx_valid      = (rstate_q == R_DATA) && !buf_empty;
  assign tx_data       = tx_valid ? buf_head[DATA_WIDTH:1] : '0;
  assign tx_last       = tx_valid && buf_head[0];
  assign tx_keep       = {(DATA_WIDTH/8){run_q}};
  assign pkt_count     = pkt_q;
  assign trunc_count   = trunc_q;

endmodule

// File: doc/muu_resp_framer.md
Name: muu_resp_framer

Overview:
- Store-and-forward response framer that sits directly downstream of the value-get stage.
- Consumes that stage's {meta, 512-bit word} stream with last/user, and buffers whole response packets.
- For each packet, emits one TX metadata beat carrying session and byte length, then the data words, to the TCP TX interface.
- The TCP engine needs the length before payload, so no data word leaves before its metadata beat is accepted.

Parameters:
- META_WIDTH, 96, width of per-word metadata from upstream.
- DATA_WIDTH, 512, payload word width; fixed to 512.
- SESSION_LSB, 0, bit offset of the 16-bit session id inside the metadata.
- DEPTH_LOG2, 5, log2 of the data buffer depth (32 words); also the maximum packet length in words.
- MQ_DEPTH_LOG2, 2, log2 of the length/meta queue depth (4 packets).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-low (rst==0 resets).
- in_data  in  META_WIDTH+512  {meta, word} from the value-get stage.
- in_user  in  8  user id of the packet; sampled on the first word.
- in_valid  in  1  upstream word valid.
- in_last  in  1  last word of the response packet.
- in_ready  out  1  framer accepts the word this cycle.
- tx_meta_data  out  32  {session[15:0], length_bytes[15:0]}.
- tx_meta_user  out  8  user id of the packet.
- tx_meta_valid  out  1  metadata beat valid.
- tx_meta_ready  in  1  TCP TX accepts metadata.
- tx_data  out  512  payload word.
- tx_keep  out  64  byte enables; always all ones.
- tx_valid  out  1  payload valid.
- tx_last  out  1  last payload word of the packet.
- tx_ready  in  1  TCP TX accepts payload.
- pkt_count  out  32  packets whose metadata has been accepted.
- trunc_count  out  16  packets force-terminated at the depth limit.

Behaviour:
- Reset: while rst==0, every output is 0 (in_ready, tx_* valids, last, data, meta, counters). Buffer pointers, queue pointers and both FSMs clear.
- Reset mid-packet: a partial packet is discarded; no metadata is emitted for it.
- Buffer: DEPTH-entry word FIFO storing {word, last}.
- Meta queue: MQ entries of {session, user, length}.
- in_ready is combinational: asserted when the word FIFO is not full and the meta queue is not full.
- Write FSM states:
  - W_IDLE: on the first accepted word, latch session = in_data[512+SESSION_LSB +: 16] and in_user, set wcnt=1, go to W_FILL. If in_last is also set, push meta immediately and stay in W_IDLE.
  - W_FILL: each accepted word increments wcnt. On in_last, push {session, user, wcnt*64} and return to W_IDLE.
- Truncation: if wcnt reaches 2**DEPTH_LOG2 without last:
  - that word is stored with last=1;
  - meta is pushed with length = DEPTH*64;
  - trunc_count increments, saturating at 16'hFFFF;
  - the FSM returns to W_IDLE, so subsequent upstream words start a new packet.
- Length arithmetic: length_bytes = wcnt<<6, 16 bits; the maximum 2048 fits. wcnt width is DEPTH_LOG2+1.
- Read FSM states:
  - R_IDLE: when the meta queue is non-empty, register the head into tx_meta_* and assert tx_meta_valid next cycle; go to R_META.
  - R_META: hold tx_meta_valid until tx_meta_ready. On handshake: pop the queue, drop tx_meta_valid, pkt_count+1 (wraps), go to R_DATA.
  - R_DATA: present the FIFO head on tx_data/tx_last with tx_valid. Pop on tx_valid&&tx_ready. When the popped word has last=1, go to R_IDLE.
- Handshakes: tx_meta_valid and tx_valid are never asserted together. Once asserted, a valid stays high with stable data until it is accepted.
- Latency: last word accepted at cycle N → tx_meta_valid at N+2. Metadata handshake at cycle M → first tx_valid at M+1.
- Throughput: one word/cycle on each side.
- Simultaneous events:
  - A FIFO push and pop in the same cycle keep the occupancy unchanged.
  - A meta push and pop in the same cycle are legal.
  - A full FIFO with a pop in the same cycle still deasserts in_ready that cycle, because in_ready looks at occupancy only, not the pop.
- Pointers wrap modulo depth, using an extra MSB for the full/empty distinction.
- Deadlock freedom: a packet longer than DEPTH cannot stall, because the truncation rule closes it at DEPTH words.

Test Plan:
- Single packet:
  - stimulus: 3 words, session 0x0042, user 5, last on word 3, both tx readys held high;
  - response: tx_meta_data=0x004200C0, tx_meta_user=5, then 3 tx_valid words with tx_last on the third, pkt_count=1.
- Single-word packet (in_last on the first word) → tx_meta_data length 0x0040; one tx word with tx_last=1.
- Back-pressure:
  - stimulus: tx_meta_ready low for 10 cycles while 5 packets of 1 word arrive;
  - response: in_ready drops after 4 packets are queued; order and lengths are preserved after release; no tx_valid before each meta handshake.
- Truncation: a 40-word stream with no last → first packet length 2048 (0x0800), tx_last on word 32, trunc_count=1. The remaining 8 words form a second packet when last arrives.
- Random tx_ready/tx_meta_ready toggling over 100 packets of 1–32 words → payload matches a scoreboard exactly and each length equals words*64.
- Reset mid-packet:
  - stimulus: rst pulled low after 2 of 4 words, then released;
  - response: all outputs 0 during reset, no meta emitted for the partial packet, and the next full packet frames correctly.
